// File: rtl/bch_decoder_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bch_decoder_seq                                              |
// | Description : Multi-cycle binary BCH decoder (syndromes, iBM, Chien search)|
// |               with valid/ready handshakes on both sides.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bch_decoder_seq #(
  parameter int         M         = 4,
  parameter int         N         = 15,
  parameter int         T         = 3,
  parameter logic [M:0] PRIM_POLY = 5'b10011,
  parameter int         CW        = $clog2(T+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] out_err_cnt,
  output logic          out_uncorr
);

  localparam int c_cntw = $clog2(N+1);
  localparam int c_lw   = $clog2(2*T);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_synd  = 3'd1;
  localparam logic [2:0] c_st_chk   = 3'd2;
  localparam logic [2:0] c_st_bm    = 3'd3;
  localparam logic [2:0] c_st_chien = 3'd4;
  localparam logic [2:0] c_st_out   = 3'd5;

  localparam logic [M-1:0]      c_one     = {{(M-1){1'b0}}, 1'b1};
  localparam logic [c_cntw-1:0] c_top     = c_cntw'(N-1);
  localparam logic [c_cntw-1:0] c_bm_last = c_cntw'(T-1);

  function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
    return a[M-1] ? ((a << 1) ^ PRIM_POLY[M-1:0]) : (a << 1);
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  function automatic logic [M-1:0] gf_pow(input int e);
    logic [M-1:0] p;
    p = c_one;
    for (int i = 0; i < e; i++) p = gf_xtime(p);
    return p;
  endfunction

  logic [2:0]        r_state;
  logic [N-1:0]      r_rw;
  logic [c_cntw-1:0] r_cnt;
  logic [M-1:0]      r_synd  [1:2*T];
  logic [M-1:0]      r_sigma [0:T];
  logic [M-1:0]      r_b     [0:T];
  logic [M-1:0]      r_term  [0:T];
  logic [M-1:0]      r_gamma;
  logic [c_lw-1:0]   r_l;
  logic [N-1:0]      r_mask;
  logic [c_cntw-1:0] r_roots;

  logic              w_bit;
  logic [M-1:0]      w_synd_next [1:2*T];
  logic              w_synd_zero;
  logic [M-1:0]      w_delta;
  logic              w_upd;
  logic [c_lw-1:0]   w_l_next;
  logic [M-1:0]      w_sig_next  [0:T];
  logic [M-1:0]      w_b_next    [0:T];
  logic [M-1:0]      w_term_next [0:T];
  logic [M-1:0]      w_sum;
  logic              w_root;
  logic [N-1:0]      w_mask_next;
  logic [c_cntw-1:0] w_roots_next;
  logic              w_fail;

  assign in_ready = (r_state == c_st_idle);
  assign w_bit    = r_rw[c_top - r_cnt];

  // Horner step S_j = S_j * alpha^j + bit, highest-order bit first
  for (genvar j = 1; j <= 2*T; j++) begin : g_synd
    localparam logic [M-1:0] c_mul = gf_pow(j);
    assign w_synd_next[j] = gf_mul(r_synd[j], c_mul) ^ {{(M-1){1'b0}}, w_bit};
  end

  // alpha^(N-j) = alpha^(-j): term_j walks sigma_j * alpha^(-j*i)
  for (genvar j = 0; j <= T; j++) begin : g_chien
    localparam logic [M-1:0] c_mul = gf_pow(N - j);
    assign w_term_next[j] = gf_mul(r_term[j], c_mul);
  end

  always_comb begin
    w_synd_zero = 1'b1;
    for (int j = 1; j <= 2*T; j++)
      if (r_synd[j] != '0) w_synd_zero = 1'b0;
  end

  // Binary iBM: only odd steps carry a discrepancy, so B advances by x^2 when not replaced
  always_comb begin
    w_delta = '0;
    for (int i = 0; i <= T; i++)
      for (int s = 1; s <= 2*T; s++)
        if (s + i == 2*int'(r_cnt) + 1) w_delta = w_delta ^ gf_mul(r_sigma[i], r_synd[s]);
    w_upd    = (w_delta != '0) && (int'(r_l) <= int'(r_cnt));
    w_l_next = r_l;
    if (w_upd) w_l_next = c_lw'(2*int'(r_cnt) + 1 - int'(r_l));
    w_sig_next[0] = gf_mul(r_gamma, r_sigma[0]);
    for (int i = 1; i <= T; i++)
      w_sig_next[i] = gf_mul(r_gamma, r_sigma[i]) ^ gf_mul(w_delta, r_b[i-1]);
    for (int i = 0; i <= T; i++) w_b_next[i] = '0;
    if (w_upd) begin
      for (int i = 1; i <= T; i++) w_b_next[i] = r_sigma[i-1];
    end else begin
      for (int i = 2; i <= T; i++) w_b_next[i] = r_b[i-2];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int j = 0; j <= T; j++) w_sum = w_sum ^ r_term[j];
    w_root       = (w_sum == '0);
    w_mask_next  = r_mask | ({{(N-1){1'b0}}, w_root} << r_cnt);
    w_roots_next = r_roots + c_cntw'(w_root);
    w_fail       = (int'(r_l) > T) || (int'(w_roots_next) != int'(r_l));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_rw        <= '0;
      r_cnt       <= '0;
      r_gamma     <= '0;
      r_l         <= '0;
      r_mask      <= '0;
      r_roots     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_err_cnt <= '0;
      out_uncorr  <= 1'b0;
      for (int j = 1; j <= 2*T; j++) r_synd[j] <= '0;
      for (int i = 0; i <= T; i++) begin
        r_sigma[i] <= '0;
        r_b[i]     <= '0;
        r_term[i]  <= '0;
      end
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_rw    <= in_data;
            r_cnt   <= '0;
            r_state <= c_st_synd;
            for (int j = 1; j <= 2*T; j++) r_synd[j] <= '0;
          end
        end
        c_st_synd: begin
          for (int j = 1; j <= 2*T; j++) r_synd[j] <= w_synd_next[j];
          if (r_cnt == c_top) begin
            r_cnt   <= '0;
            r_state <= c_st_chk;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_st_chk: begin
          if (w_synd_zero) begin
            out_valid   <= 1'b1;
            out_data    <= r_rw;
            out_err_cnt <= '0;
            out_uncorr  <= 1'b0;
            r_state     <= c_st_out;
          end else begin
            for (int i = 0; i <= T; i++) begin
              r_sigma[i] <= (i == 0) ? c_one : '0;
              r_b[i]     <= (i == 0) ? c_one : '0;
            end
            r_gamma <= c_one;
            r_l     <= '0;
            r_cnt   <= '0;
            r_state <= c_st_bm;
          end
        end
        c_st_bm: begin
          for (int i = 0; i <= T; i++) begin
            r_sigma[i] <= w_sig_next[i];
            r_b[i]     <= w_b_next[i];
          end
          if (w_upd) r_gamma <= w_delta;
          r_l <= w_l_next;
          if (r_cnt == c_bm_last) begin
            for (int i = 0; i <= T; i++) r_term[i] <= w_sig_next[i];
            r_mask  <= '0;
            r_roots <= '0;
            r_cnt   <= '0;
            r_state <= c_st_chien;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_st_chien: begin
          for (int i = 0; i <= T; i++) r_term[i] <= w_term_next[i];
          r_mask  <= w_mask_next;
          r_roots <= w_roots_next;
          if (r_cnt == c_top) begin
            out_valid <= 1'b1;
            r_state   <= c_st_out;
            if (w_fail) begin
              out_data    <= r_rw;
              out_err_cnt <= '0;
              out_uncorr  <= 1'b1;
            end else begin
              out_data    <= r_rw ^ w_mask_next;
              out_err_cnt <= r_l[CW-1:0];
              out_uncorr  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_st_out: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire
